// File: rtl/cc_pattern_driver.sv
// Candy-board transmit driver: serialises one stored game onto in_valid_1/in_valid_2 and reports the engine's reply.
// Optional macro CC_DRV_SCORE_CHECK_EN adds an expected-score register and the score_mismatch flag.
module cc_pattern_driver #(
    parameter int BOARD_CELLS = 36,
    parameter int NUM_STRIPES = 4,
    parameter int MAX_ACTIONS = 10,
    parameter int GAP_CYCLES  = 1,
    parameter int TIMEOUT     = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [1:0] cfg_sel,
    input  logic [5:0] cfg_addr,
    input  logic [8:0] cfg_wdata,
    input  logic [3:0] act_count,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [6:0] score,
    output logic       timeout_err,
    output logic       score_mismatch,
    output logic       in_valid_1,
    output logic       in_valid_2,
    output logic [2:0] in_color,
    output logic       in_stripe,
    output logic [1:0] in_action,
    output logic [5:0] in_starting_pos,
    input  logic       out_valid,
    input  logic [6:0] out_score
);

    localparam int SW = (NUM_STRIPES > 1) ? $clog2(NUM_STRIPES) : 1;
    localparam int AW = (MAX_ACTIONS > 1) ? $clog2(MAX_ACTIONS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BOARD = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0] color_q  [BOARD_CELLS];
    logic [6:0] stripe_q [NUM_STRIPES];
    logic [7:0] action_q [MAX_ACTIONS];

    logic [2:0] state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] n_q, n_d;
    logic [6:0] score_q, score_d;
    logic       terr_q, terr_d;
    logic       cfg_open;
    logic [3:0] n_clamped;

    assign cfg_open  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign n_clamped = (act_count == 4'd0) ? 4'd1 :
                       (act_count > 4'(MAX_ACTIONS)) ? 4'(MAX_ACTIONS) : act_count;

`ifdef CC_DRV_SCORE_CHECK_EN
    logic [6:0] exp_q;
    logic       mm_q, mm_d;
`endif

    // Configuration stores; writes only land while no game is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BOARD_CELLS; i++) color_q[i] <= '0;
            for (int i = 0; i < NUM_STRIPES; i++) stripe_q[i] <= '0;
            for (int i = 0; i < MAX_ACTIONS; i++) action_q[i] <= '0;
`ifdef CC_DRV_SCORE_CHECK_EN
            exp_q <= '0;
`endif
        end else if (cfg_we && cfg_open) begin
            case (cfg_sel)
                2'd0: if (cfg_addr < 6'(BOARD_CELLS)) color_q[cfg_addr] <= cfg_wdata[2:0];
                2'd1: if (cfg_addr < 6'(NUM_STRIPES)) stripe_q[cfg_addr[SW-1:0]] <= cfg_wdata[6:0];
                2'd2: if (cfg_addr < 6'(MAX_ACTIONS))
                          action_q[cfg_addr[AW-1:0]] <= {cfg_wdata[8:7], cfg_wdata[5:0]};
`ifdef CC_DRV_SCORE_CHECK_EN
                2'd3: exp_q <= cfg_wdata[6:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        score_d = score_q;
        terr_d  = terr_q;
`ifdef CC_DRV_SCORE_CHECK_EN
        mm_d    = mm_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_BOARD;
                cnt_d   = '0;
                n_d     = n_clamped;
                score_d = '0;
                terr_d  = 1'b0;
`ifdef CC_DRV_SCORE_CHECK_EN
                mm_d    = 1'b0;
`endif
            end
            S_BOARD: if (cnt_q == 10'(BOARD_CELLS - 1)) begin
                state_d = S_GAP;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 10'd1;
            S_GAP: if (cnt_q == 10'(GAP_CYCLES - 1)) begin
                state_d = S_ACT;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 10'd1;
            S_ACT: if (cnt_q == {6'd0, n_q} - 10'd1) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 10'd1;
            // A reply on the last permitted cycle still wins over the timeout.
            S_WAIT: if (out_valid) begin
                state_d = S_DONE;
                score_d = out_score;
`ifdef CC_DRV_SCORE_CHECK_EN
                mm_d    = (out_score != exp_q);
`endif
            end else if (cnt_q == 10'(TIMEOUT - 1)) begin
                state_d = S_DONE;
                score_d = '0;
                terr_d  = 1'b1;
`ifdef CC_DRV_SCORE_CHECK_EN
                mm_d    = 1'b1;
`endif
            end else cnt_d = cnt_q + 10'd1;
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            score_q <= '0;
            terr_q  <= 1'b0;
`ifdef CC_DRV_SCORE_CHECK_EN
            mm_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            score_q <= score_d;
            terr_q  <= terr_d;
`ifdef CC_DRV_SCORE_CHECK_EN
            mm_q    <= mm_d;
`endif
        end
    end

    // Protocol outputs decode straight from state so nothing stale leaks outside a phase.
    always_comb begin
        in_valid_1      = 1'b0;
        in_valid_2      = 1'b0;
        in_color        = '0;
        in_stripe       = 1'b0;
        in_action       = '0;
        in_starting_pos = '0;
        case (state_q)
            S_BOARD: begin
                in_valid_1 = 1'b1;
                in_color   = color_q[cnt_q[5:0]];
                if (cnt_q < 10'(NUM_STRIPES)) begin
                    in_stripe       = stripe_q[cnt_q[SW-1:0]][6];
                    in_starting_pos = stripe_q[cnt_q[SW-1:0]][5:0];
                end
            end
            S_ACT: begin
                in_valid_2      = 1'b1;
                in_action       = action_q[cnt_q[AW-1:0]][7:6];
                in_starting_pos = action_q[cnt_q[AW-1:0]][5:0];
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign score       = score_q;
    assign timeout_err = terr_q;
`ifdef CC_DRV_SCORE_CHECK_EN
    assign score_mismatch = mm_q;
`else
    assign score_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cc_pattern_driver.sv
// Randomised bench for cc_pattern_driver: a per-cycle expected output trace is built from the stored game contents.
module tb_cc_pattern_driver;

    localparam int BOARD   = 36;
    localparam int STRIPES = 4;
    localparam int MAXA    = 10;
    localparam int GAP     = 1;
    localparam int TMO     = 1023;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic [5:0] cfg_addr = '0;
    logic [8:0] cfg_wdata = '0;
    logic [3:0] act_count = '0;
    logic       start = 1'b0;
    logic       out_valid = 1'b0;
    logic [6:0] out_score = '0;
    logic       busy, done, timeout_err, score_mismatch;
    logic       in_valid_1, in_valid_2, in_stripe;
    logic [6:0] score;
    logic [2:0] in_color;
    logic [1:0] in_action;
    logic [5:0] in_starting_pos;

    cc_pattern_driver dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .act_count(act_count), .start(start), .busy(busy), .done(done),
        .score(score), .timeout_err(timeout_err), .score_mismatch(score_mismatch),
        .in_valid_1(in_valid_1), .in_valid_2(in_valid_2), .in_color(in_color),
        .in_stripe(in_stripe), .in_action(in_action), .in_starting_pos(in_starting_pos),
        .out_valid(out_valid), .out_score(out_score)
    );

    always #5 clk = ~clk;

    int errorCount = 0;
    int checkCount = 0;

    logic [2:0] colorM  [BOARD];
    logic [6:0] stripeM [STRIPES];
    logic [8:0] actionM [MAXA];
    logic [6:0] expM = '0;

    int         optNoise = -1;
    int         optPoke  = -1;
    int         optRstAt = -1;
    bit         optSameWr = 0;
    logic [5:0] sameAddr = '0;
    logic [8:0] sameData = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelWrite(input logic [1:0] sel, input logic [5:0] addr, input logic [8:0] data);
        case (sel)
            2'd0: if (addr < BOARD) colorM[addr] = data[2:0];
            2'd1: if (addr < STRIPES) stripeM[addr] = data[6:0];
            2'd2: if (addr < MAXA) actionM[addr] = data;
            default: begin
`ifdef CC_DRV_SCORE_CHECK_EN
                expM = data[6:0];
`endif
            end
        endcase
    endtask

    task automatic modelClear();
        for (int i = 0; i < BOARD; i++) colorM[i] = '0;
        for (int i = 0; i < STRIPES; i++) stripeM[i] = '0;
        for (int i = 0; i < MAXA; i++) actionM[i] = '0;
        expM = '0;
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [5:0] addr, input logic [8:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        modelWrite(sel, addr, data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    function automatic logic [15:0] observedVec();
        return {busy, done, in_valid_1, in_valid_2, in_color, in_stripe, in_action, in_starting_pos};
    endfunction

    // Cycle i counts from the first cycle after the accepted start.
    function automatic logic [15:0] expAt(int i, int n, int doneIdx);
        logic [8:0] a;
        if (i == doneIdx) return 16'h4000;
        if (i < BOARD) begin
            if (i < STRIPES) return {4'b1010, colorM[i], stripeM[i][6], 2'b00, stripeM[i][5:0]};
            return {4'b1010, colorM[i], 1'b0, 2'b00, 6'd0};
        end
        if (i >= BOARD + GAP && i < BOARD + GAP + n) begin
            a = actionM[i - BOARD - GAP];
            return {4'b1001, 3'd0, 1'b0, a[8:7], a[5:0]};
        end
        return 16'h8000;
    endfunction

    task automatic runGame(input int actCount, input int replyAt, input logic [6:0] replyScore);
        int n, doneIdx;
        logic expMm;
        n = (actCount == 0) ? 1 : (actCount > MAXA) ? MAXA : actCount;
        doneIdx = BOARD + GAP + n + ((replyAt >= 0) ? replyAt + 1 : TMO);
`ifdef CC_DRV_SCORE_CHECK_EN
        expMm = (replyAt < 0) || (replyScore != expM);
`else
        expMm = 1'b0;
`endif
        start = 1'b1;
        act_count = 4'(actCount);
        if (optSameWr) begin
            cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = sameAddr; cfg_wdata = sameData;
            modelWrite(2'd0, sameAddr, sameData);
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        for (int i = 0; i <= doneIdx; i++) begin
            if (i == optRstAt) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                modelClear();
                @(negedge clk);
                checkOutput("rstOutputs", {16'(observedVec()), 7'd0, score, timeout_err, score_mismatch}, 32'd0);
                @(posedge clk); #1;
                optRstAt = -1;
                return;
            end
            out_valid = ((replyAt >= 0) && (i == doneIdx - 1)) || (i == optNoise);
            out_score = (i == doneIdx - 1) ? replyScore : 7'($urandom_range(1, 127));
            if (i == optPoke) begin
                start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 6'd0;
                cfg_wdata = 9'((colorM[0] + 3'd1) % 3'd6);
            end
            if (i == doneIdx) start = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("cycle%0d", i), 32'(observedVec()), 32'(expAt(i, n, doneIdx)));
            if (i == 0) checkOutput("clearOnStart", {29'd0, timeout_err, score_mismatch, |score}, 32'd0);
            if (i == doneIdx) begin
                checkOutput("score", 32'(score), (replyAt >= 0) ? 32'(replyScore) : 32'd0);
                checkOutput("timeoutErr", 32'(timeout_err), (replyAt < 0) ? 32'd1 : 32'd0);
                checkOutput("scoreMismatch", 32'(score_mismatch), 32'(expMm));
            end
            @(posedge clk); #1;
            out_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
        end
        @(negedge clk);
        checkOutput("idleAfterDone", 32'(observedVec()), 32'd0);
        checkOutput("scoreHeld", 32'(score), (replyAt >= 0) ? 32'(replyScore) : 32'd0);
        @(posedge clk); #1;
        optNoise = -1; optPoke = -1; optSameWr = 0;
    endtask

    task automatic randomGame();
        int v;
        for (int p = 0; p < BOARD; p++) begin
            v = $urandom_range(0, 6);
            applyStimulus(2'd0, 6'(p), 9'((v == 6) ? 7 : v));
        end
        for (int s = 0; s < STRIPES; s++) applyStimulus(2'd1, 6'(s), 9'($urandom_range(0, 127)));
        for (int a = 0; a < MAXA; a++) applyStimulus(2'd2, 6'(a), 9'($urandom_range(0, 511)));
        runGame($urandom_range(0, 15), $urandom_range(0, 15), 7'($urandom_range(0, 127)));
    endtask

    initial begin
        modelClear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("resetOutputs", {16'(observedVec()), 7'd0, score, timeout_err, score_mismatch}, 32'd0);
        @(posedge clk); #1;

        // Basic game: colors follow pos%6, three actions, reply on wait cycle 4.
        for (int p = 0; p < BOARD; p++) applyStimulus(2'd0, 6'(p), 9'(p % 6));
        for (int s = 0; s < STRIPES; s++) applyStimulus(2'd1, 6'(s), 9'd0);
        for (int a = 0; a < MAXA; a++) applyStimulus(2'd2, 6'(a), 9'($urandom_range(0, 511)));
        runGame(3, 4, 7'd5);

        // Stripe entry 2 is vertical at 0o23; out-of-range stripe address must not alias.
        applyStimulus(2'd1, 6'd2, 9'h053);
        applyStimulus(2'd1, 6'd5, 9'h07F);
        applyStimulus(2'd2, 6'd12, 9'h1FF);
        runGame(2, 0, 7'd7);

        runGame(0, 1, 7'd3);
        runGame(15, 1, 7'd4);

        optNoise = 10;
        runGame(2, -1, 7'd0);

        optPoke = 5;
        runGame(4, 3, 7'd11);
        optRstAt = BOARD + GAP + 1;
        runGame(4, 3, 7'd0);
        runGame(2, 2, 7'd6);

        optSameWr = 1; sameAddr = 6'd0; sameData = 9'd4;
        runGame(1, 0, 7'd1);

        applyStimulus(2'd3, 6'd0, 9'd9);
        runGame(2, 2, 7'd9);
        runGame(2, 2, 7'd8);

        for (int g = 0; g < 5; g++) randomGame();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
